// File: rtl/dffram_arb_pkg.sv
// Shared types for the DFFRAM arbiter and its two-way arbitration primitive.
// Port indices double as bit positions in the req/gnt vectors.
package dffram_arb_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    localparam int NUM_PORTS = 2;

    // Per-port response state captured at grant time, presented one cycle later.
    typedef struct packed {
        logic rvalid;
        logic err;
        logic is_read;
    } resp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter with one-hot grant output.
// Build option DFFRAM_ARB_RR_EN: when defined, contested cycles alternate
// between the requesters using a last-winner pointer; when undefined, the
// data requester has fixed priority and no state exists.
module rr_arb2
    import dffram_arb_pkg::*;
(
`ifdef DFFRAM_ARB_RR_EN
    input  logic                 clk_i,
    input  logic                 rst_i,
`endif
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

`ifdef DFFRAM_ARB_RR_EN
    port_e last_q;

    // Contested cycles go to the port that did not win the last contest.
    always_comb begin
        gnt_o = req_i;
        if (req_i[PORT_DATA] && req_i[PORT_INSTR]) begin
            gnt_o = '0;
            if (last_q == PORT_INSTR) gnt_o[PORT_DATA]  = 1'b1;
            else                      gnt_o[PORT_INSTR] = 1'b1;
        end
    end

    // Pointer moves only when both ports competed; reset favours data first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= PORT_INSTR;
        end else if (req_i[PORT_DATA] && req_i[PORT_INSTR]) begin
            last_q <= gnt_o[PORT_DATA] ? PORT_DATA : PORT_INSTR;
        end
    end
`else
    // Fixed priority: data always beats instruction fetch.
    always_comb begin
        gnt_o             = '0;
        gnt_o[PORT_DATA]  = req_i[PORT_DATA];
        gnt_o[PORT_INSTR] = req_i[PORT_INSTR] & ~req_i[PORT_DATA];
    end
`endif

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between the instruction-fetch and data ports.
// Grants are combinational, responses arrive exactly one cycle after grant.
// Build option DFFRAM_ARB_RR_EN selects round-robin arbitration (see rr_arb2).
module dffram_arbiter
    import dffram_arb_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,
    input  logic              data_req_i,
    input  logic [31:0]       data_addr_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_err_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [31:0]       ram_di_o,
    input  logic [31:0]       ram_do_i
);

    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
    endfunction

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt;
    logic                 instr_in, data_in;
    logic                 win_in, win_wr;
    logic [ADDR_W-1:0]    win_idx;
    logic [ADDR_W-1:0]    ram_a_q;
    logic [31:0]          ram_di_q;
    resp_t                instr_rsp_d, instr_rsp_q;
    resp_t                data_rsp_d, data_rsp_q;

    // Byte-offset bits never affect a word access.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    assign req[PORT_INSTR] = instr_req_i;
    assign req[PORT_DATA]  = data_req_i;
    assign instr_in        = addr_in_range(instr_addr_i);
    assign data_in         = addr_in_range(data_addr_i);

    rr_arb2 u_arb (
`ifdef DFFRAM_ARB_RR_EN
        .clk_i (CLK),
        .rst_i (RST),
`endif
        .req_i (req),
        .gnt_o (gnt)
    );

    assign instr_gnt_o = gnt[PORT_INSTR];
    assign data_gnt_o  = gnt[PORT_DATA];

    // RAM-control mux: the winner drives the RAM; address and write data
    // hold their previous value whenever the RAM is not enabled.
    always_comb begin
        win_in   = 1'b0;
        win_wr   = 1'b0;
        win_idx  = instr_addr_i[ADDR_W+1:2];
        ram_en_o = 1'b0;
        ram_we_o = 4'b0000;
        ram_a_o  = ram_a_q;
        ram_di_o = ram_di_q;
        if (gnt[PORT_DATA]) begin
            win_in  = data_in;
            win_wr  = data_we_i;
            win_idx = data_addr_i[ADDR_W+1:2];
        end else if (gnt[PORT_INSTR]) begin
            win_in  = instr_in;
        end
        if (win_in) begin
            ram_en_o = 1'b1;
            ram_a_o  = win_idx;
            if (win_wr) begin
                ram_we_o = data_be_i;
                ram_di_o = data_wdata_i;
            end
        end
    end

    // Hold registers for the RAM address and write-data buses (datapath, no reset).
    always_ff @(posedge CLK) begin
        ram_a_q  <= ram_a_o;
        ram_di_q <= ram_di_o;
    end

    // Next response per port: valid on grant, error when out of range,
    // read data forwarded only for an in-range read.
    always_comb begin
        instr_rsp_d.rvalid  = gnt[PORT_INSTR];
        instr_rsp_d.err     = gnt[PORT_INSTR] & ~instr_in;
        instr_rsp_d.is_read = gnt[PORT_INSTR] & instr_in;
        data_rsp_d.rvalid   = gnt[PORT_DATA];
        data_rsp_d.err      = gnt[PORT_DATA] & ~data_in;
        data_rsp_d.is_read  = gnt[PORT_DATA] & data_in & ~data_we_i;
    end

    // Response registers; reset drops any pending response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_rsp_q <= '0;
            data_rsp_q  <= '0;
        end else begin
            instr_rsp_q <= instr_rsp_d;
            data_rsp_q  <= data_rsp_d;
        end
    end

    assign instr_rvalid_o = instr_rsp_q.rvalid;
    assign instr_err_o    = instr_rsp_q.err;
    assign instr_rdata_o  = instr_rsp_q.is_read ? ram_do_i : 32'h0;
    assign data_rvalid_o  = data_rsp_q.rvalid;
    assign data_err_o     = data_rsp_q.err;
    assign data_rdata_o   = data_rsp_q.is_read ? ram_do_i : 32'h0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural byte-masked RAM.
// RAM word i starts as {16'hC0DE, i}.
module tb_dffram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [11:0] ram_a_o;
    logic [31:0] ram_di_o;
    logic [31:0] ram_do_i;

    int checks = 0;
    int errors = 0;

    dffram_arbiter #(.ADDR_W(12), .BASE_ADDR(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_a_o(ram_a_o),
        .ram_di_o(ram_di_o), .ram_do_i(ram_do_i)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:4095];
    bit          init_done;

    always @(posedge CLK) begin
        if (!init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= {16'hC0DE, 16'(i)};
            init_done <= 1'b1;
        end else if (ram_en_o) begin
            ram_do_i <= mem[ram_a_o];
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) mem[ram_a_o][b*8 +: 8] <= ram_di_o[b*8 +: 8];
        end
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
        data_be_i   = 4'b0000;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++;
            $display("FAIL reset_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
        checks++; if ({instr_err_o, data_err_o} !== 2'b00) begin errors++;
            $display("FAIL reset_err: got %b want 00", {instr_err_o, data_err_o}); end
        checks++; if ((instr_rdata_o | data_rdata_o) !== 32'h0) begin errors++;
            $display("FAIL reset_rdata: got %h/%h want 0", instr_rdata_o, data_rdata_o); end
        checks++; if ({ram_en_o, ram_we_o} !== 5'b0) begin errors++;
            $display("FAIL reset_ram: got en=%b we=%b want 0/0", ram_en_o, ram_we_o); end
        RST = 1'b0;
    endtask

    task automatic test_instr_read();
        instr_req_i = 1'b1; instr_addr_i = 32'h10;
        #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++;
            $display("FAIL ird_gnt: got i/d=%b want 10", {instr_gnt_o, data_gnt_o}); end
        checks++; if ({ram_en_o, ram_we_o, ram_a_o} !== {1'b1, 4'b0, 12'd4}) begin errors++;
            $display("FAIL ird_ram: got en=%b we=%b a=%h want 1/0/004", ram_en_o, ram_we_o, ram_a_o); end
        cycle(); idle(); #1;
        checks++; if ({instr_rvalid_o, instr_err_o, data_rvalid_o} !== 3'b100) begin errors++;
            $display("FAIL ird_rsp: got rv=%b err=%b drv=%b want 1/0/0", instr_rvalid_o, instr_err_o, data_rvalid_o); end
        checks++; if (instr_rdata_o !== 32'hC0DE0004) begin errors++;
            $display("FAIL ird_rdata: got %h want C0DE0004", instr_rdata_o); end
    endtask

    task automatic test_write_read();
        cycle();
        data_req_i = 1'b1; data_addr_i = 32'h20; data_we_i = 1'b1;
        data_be_i = 4'b0101; data_wdata_i = 32'hAABBCCDD;
        #1;
        checks++; if (data_gnt_o !== 1'b1) begin errors++;
            $display("FAIL wr_gnt: got %b want 1", data_gnt_o); end
        checks++; if ({ram_en_o, ram_we_o, ram_a_o, ram_di_o} !== {1'b1, 4'b0101, 12'd8, 32'hAABBCCDD}) begin errors++;
            $display("FAIL wr_ram: got en=%b we=%b a=%h di=%h want 1/0101/008/AABBCCDD", ram_en_o, ram_we_o, ram_a_o, ram_di_o); end
        cycle();
        data_we_i = 1'b0; data_be_i = 4'b0000;
        #1;
        checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h0}) begin errors++;
            $display("FAIL wr_rsp: got rv=%b err=%b rd=%h want 1/0/0", data_rvalid_o, data_err_o, data_rdata_o); end
        checks++; if ({data_gnt_o, ram_en_o, ram_we_o} !== {2'b11, 4'b0}) begin errors++;
            $display("FAIL rd_b2b_ram: got gnt=%b en=%b we=%b want 1/1/0", data_gnt_o, ram_en_o, ram_we_o); end
        cycle(); idle(); #1;
        checks++; if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'hC0BB00DD}) begin errors++;
            $display("FAIL rd_merge: got rv=%b rd=%h want 1/C0BB00DD", data_rvalid_o, data_rdata_o); end
    endtask

    task automatic test_contention();
        int   d_cnt = 0;
        logic exp_d;
        logic prev_d = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            instr_req_i = 1'b1; instr_addr_i = 32'h40;
            data_req_i = 1'b1; data_addr_i = 32'h44; data_we_i = 1'b0;
            #1;
`ifdef DFFRAM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            checks++; if ({data_gnt_o, instr_gnt_o} !== {exp_d, ~exp_d}) begin errors++;
                $display("FAIL arb_gnt[%0d]: got d/i=%b want %b", k, {data_gnt_o, instr_gnt_o}, {exp_d, ~exp_d}); end
            checks++; if (ram_a_o !== (exp_d ? 12'd17 : 12'd16)) begin errors++;
                $display("FAIL arb_addr[%0d]: got %h want %h", k, ram_a_o, exp_d ? 12'd17 : 12'd16); end
            if (k > 0) begin
                checks++;
                if ({data_rvalid_o, instr_rvalid_o} !== {prev_d, ~prev_d} ||
                    (prev_d ? data_rdata_o : instr_rdata_o) !== (prev_d ? 32'hC0DE0011 : 32'hC0DE0010)) begin
                    errors++;
                    $display("FAIL arb_rsp[%0d]: got drv/irv=%b rd=%h/%h prev_d=%b", k,
                             {data_rvalid_o, instr_rvalid_o}, data_rdata_o, instr_rdata_o, prev_d);
                end
            end
            d_cnt += int'(data_gnt_o);
            prev_d = exp_d;
        end
        cycle(); idle(); #1;
        checks++; if ({data_rvalid_o, instr_rvalid_o} !== {prev_d, ~prev_d}) begin errors++;
            $display("FAIL arb_last_rsp: got drv/irv=%b want %b", {data_rvalid_o, instr_rvalid_o}, {prev_d, ~prev_d}); end
`ifdef DFFRAM_ARB_RR_EN
        checks++; if (d_cnt !== 3) begin errors++; $display("FAIL arb_count: data grants %0d want 3", d_cnt); end
`else
        checks++; if (d_cnt !== 6) begin errors++; $display("FAIL arb_count: data grants %0d want 6", d_cnt); end
`endif
    endtask

    task automatic test_out_of_range();
        cycle();
        data_req_i = 1'b1; data_addr_i = 32'h0001_0000; data_we_i = 1'b0;
        #1;
        checks++; if ({data_gnt_o, ram_en_o, ram_we_o} !== {2'b10, 4'b0}) begin errors++;
            $display("FAIL oor_ram: got gnt=%b en=%b we=%b want 1/0/0", data_gnt_o, ram_en_o, ram_we_o); end
        cycle(); idle(); #1;
        checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b11, 32'h0}) begin errors++;
            $display("FAIL oor_rsp: got rv=%b err=%b rd=%h want 1/1/0", data_rvalid_o, data_err_o, data_rdata_o); end
        cycle();
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_3FFC;
        #1;
        checks++; if ({ram_en_o, ram_a_o} !== {1'b1, 12'hFFF}) begin errors++;
            $display("FAIL top_word: got en=%b a=%h want 1/FFF", ram_en_o, ram_a_o); end
        cycle();
        instr_addr_i = 32'h0000_4000;
        #1;
        checks++; if ({instr_rvalid_o, instr_err_o, instr_rdata_o} !== {2'b10, 32'hC0DE0FFF}) begin errors++;
            $display("FAIL top_rsp: got rv=%b err=%b rd=%h want 1/0/C0DE0FFF", instr_rvalid_o, instr_err_o, instr_rdata_o); end
        checks++; if ({instr_gnt_o, ram_en_o} !== 2'b10) begin errors++;
            $display("FAIL past_top: got gnt=%b en=%b want 1/0", instr_gnt_o, ram_en_o); end
        cycle(); idle(); #1;
        checks++; if ({instr_rvalid_o, instr_err_o, instr_rdata_o} !== {2'b11, 32'h0}) begin errors++;
            $display("FAIL past_top_rsp: got rv=%b err=%b rd=%h want 1/1/0", instr_rvalid_o, instr_err_o, instr_rdata_o); end
    endtask

    task automatic test_be_zero();
        cycle();
        data_req_i = 1'b1; data_addr_i = 32'h30; data_we_i = 1'b1;
        data_be_i = 4'b0000; data_wdata_i = 32'hFFFFFFFF;
        #1;
        checks++; if ({data_gnt_o, ram_en_o, ram_we_o, ram_a_o} !== {2'b11, 4'b0, 12'd12}) begin errors++;
            $display("FAIL be0_ram: got gnt=%b en=%b we=%b a=%h want 1/1/0/00C", data_gnt_o, ram_en_o, ram_we_o, ram_a_o); end
        cycle();
        data_we_i = 1'b0;
        #1;
        checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h0}) begin errors++;
            $display("FAIL be0_rsp: got rv=%b err=%b rd=%h want 1/0/0", data_rvalid_o, data_err_o, data_rdata_o); end
        cycle(); idle(); #1;
        checks++; if (data_rdata_o !== 32'hC0DE000C) begin errors++;
            $display("FAIL be0_readback: got %h want C0DE000C", data_rdata_o); end
    endtask

    task automatic test_reset_mid();
        cycle();
        instr_req_i = 1'b1; instr_addr_i = 32'h10;
        #1;
        checks++; if (instr_gnt_o !== 1'b1) begin errors++;
            $display("FAIL rst_mid_gnt: got %b want 1", instr_gnt_o); end
        cycle(); idle();
        RST = 1'b1;
        #1;
        checks++; if ({instr_rvalid_o, instr_err_o, instr_rdata_o, ram_en_o, ram_we_o} !== 39'b0) begin errors++;
            $display("FAIL rst_mid_out: got rv=%b err=%b rd=%h en=%b we=%b want all 0",
                     instr_rvalid_o, instr_err_o, instr_rdata_o, ram_en_o, ram_we_o); end
        RST = 1'b0;
        data_req_i = 1'b1; data_addr_i = 32'h20; data_we_i = 1'b0;
        #1;
        checks++; if ({data_gnt_o, ram_en_o} !== 2'b11) begin errors++;
            $display("FAIL first_grant: got gnt=%b en=%b want 1/1", data_gnt_o, ram_en_o); end
        cycle(); idle(); #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o, data_rdata_o} !== {2'b01, 32'hC0BB00DD}) begin errors++;
            $display("FAIL post_rst_rsp: got irv=%b drv=%b rd=%h want 0/1/C0BB00DD", instr_rvalid_o, data_rvalid_o, data_rdata_o); end
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_be_zero();
        test_reset_mid();
        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
